branch_resolve_queue: RTL and testbench

//  Update-side partner of the BTB: holds in-order the prediction made at fetch for each in-flight

---
 rtl/branch_resolve_queue_pkg.sv | 21 ++
 rtl/brq_fifo.sv | 71 +++++++
 rtl/branch_resolve_queue.sv | 136 +++++++++++++
 tb/tb_branch_resolve_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: LC-3b word, queue entry, and the
// prediction-vs-outcome compare used at resolve time.
package branch_resolve_queue_pkg;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    logic     hit;
    lc3b_word target;
  } brq_entry_t;

  localparam lc3b_word PC_STEP = 16'd2;

  // Wrong direction, or right direction (taken) but wrong target.
  function automatic logic is_mispredict(input brq_entry_t e, input logic taken,
                                         input lc3b_word tgt);
    return (e.hit != taken) | (e.hit & taken & (e.target != tgt));
  endfunction

endpackage

// File: rtl/brq_fifo.sv
// In-order store of fetch-time predictions. clear wins over push/pop and
// empties the queue in one edge; pointers wrap naturally at DEPTH.
module brq_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  brq_entry_t                 din,
  input  logic                       pop,
  input  logic                       clear,
  output brq_entry_t                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  brq_entry_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_eff, pop_eff;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign dout     = mem_q[rd_ptr_q];
  assign push_eff = push & ~full & ~clear;
  assign pop_eff  = pop & ~empty & ~clear;

  // Next pointer/count values; clear returns everything to the reset state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between rd and wr pointers.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds fetch-time BTB predictions in order, compares
// the head against the execute outcome, and drives the BTB update port and a
// mispredict redirect one cycle after the resolving edge.
// Optional build macro: BRQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pred_valid,
  input  logic [15:0] pred_pc,
  input  logic        pred_hit,
  input  logic [15:0] pred_target,
  output logic        pred_ready,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [15:0] res_target,
  output logic [15:0] resolved_lookup_pc,
  output logic [15:0] resolved_predicted_pc,
  output logic        check_target,
  output logic        mispredict,
  output logic [15:0] redirect_pc,
  output logic        underflow_err
`ifdef BRQ_STATS_EN
  ,
  output logic [15:0] stat_resolved,
  output logic [15:0] stat_mispredict
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  brq_entry_t    enq_entry, head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          do_push, do_pop, mispredict_d;

  lc3b_word lookup_pc_q, lookup_pc_d;
  lc3b_word predicted_pc_q, predicted_pc_d;
  lc3b_word redirect_q, redirect_d;
  logic     check_target_q, check_target_d;
  logic     mispredict_q;
  logic     underflow_q, underflow_d;

  assign enq_entry = '{pc: pred_pc, hit: pred_hit, target: pred_target};
  assign pred_ready = (fifo_count != FULL_CNT);
  assign do_push    = pred_valid & ~fifo_full;
  assign do_pop     = res_valid & ~fifo_empty;

  brq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_push),
    .din   (enq_entry),
    .pop   (do_pop),
    .clear (mispredict_d),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Resolve evaluation: strobes default low, pc/target outputs hold until the next pop.
  always_comb begin
    mispredict_d   = 1'b0;
    check_target_d = 1'b0;
    lookup_pc_d    = lookup_pc_q;
    predicted_pc_d = predicted_pc_q;
    redirect_d     = redirect_q;
    underflow_d    = underflow_q | (res_valid & fifo_empty);
    if (do_pop) begin
      mispredict_d   = is_mispredict(head, res_taken, res_target);
      check_target_d = res_taken;
      lookup_pc_d    = head.pc;
      predicted_pc_d = res_target;
      redirect_d     = res_taken ? res_target : head.pc + PC_STEP;
    end
  end

  // Registered BTB-update / redirect outputs and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_pc_q    <= '0;
      predicted_pc_q <= '0;
      redirect_q     <= '0;
      check_target_q <= 1'b0;
      mispredict_q   <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      lookup_pc_q    <= lookup_pc_d;
      predicted_pc_q <= predicted_pc_d;
      redirect_q     <= redirect_d;
      check_target_q <= check_target_d;
      mispredict_q   <= mispredict_d;
      underflow_q    <= underflow_d;
    end
  end

  assign resolved_lookup_pc    = lookup_pc_q;
  assign resolved_predicted_pc = predicted_pc_q;
  assign redirect_pc           = redirect_q;
  assign check_target          = check_target_q;
  assign mispredict            = mispredict_q;
  assign underflow_err         = underflow_q;

`ifdef BRQ_STATS_EN
  logic [15:0] stat_res_q, stat_res_d;
  logic [15:0] stat_mis_q, stat_mis_d;

  // Saturating event counters.
  always_comb begin
    stat_res_d = stat_res_q;
    stat_mis_d = stat_mis_q;
    if (do_pop && stat_res_q != '1)       stat_res_d = stat_res_q + 16'd1;
    if (mispredict_d && stat_mis_q != '1) stat_mis_d = stat_mis_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_resolved   = stat_res_q;
  assign stat_mispredict = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue (DEPTH=4). Inputs change on the
// falling edge; registered outputs are sampled on the following falling edge.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pred_valid, pred_hit, pred_ready;
  logic [15:0] pred_pc, pred_target;
  logic        res_valid, res_taken;
  logic [15:0] res_target;
  logic [15:0] resolved_lookup_pc, resolved_predicted_pc, redirect_pc;
  logic        check_target, mispredict, underflow_err;
`ifdef BRQ_STATS_EN
  logic [15:0] stat_resolved, stat_mispredict;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .pred_valid            (pred_valid),
    .pred_pc               (pred_pc),
    .pred_hit              (pred_hit),
    .pred_target           (pred_target),
    .pred_ready            (pred_ready),
    .res_valid             (res_valid),
    .res_taken             (res_taken),
    .res_target            (res_target),
    .resolved_lookup_pc    (resolved_lookup_pc),
    .resolved_predicted_pc (resolved_predicted_pc),
    .check_target          (check_target),
    .mispredict            (mispredict),
    .redirect_pc           (redirect_pc),
    .underflow_err         (underflow_err)
`ifdef BRQ_STATS_EN
    ,
    .stat_resolved         (stat_resolved),
    .stat_mispredict       (stat_mispredict)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    pred_valid = 1'b0; pred_pc = '0; pred_hit = 1'b0; pred_target = '0;
    res_valid  = 1'b0; res_taken = 1'b0; res_target = '0;
  endtask

  // One clock: apply the given inputs across a rising edge, then return to idle.
  task automatic step(input logic pv, input logic [15:0] pc, input logic hit,
                      input logic [15:0] tgt, input logic rv, input logic rt,
                      input logic [15:0] rtgt);
    pred_valid = pv; pred_pc = pc; pred_hit = hit; pred_target = tgt;
    res_valid = rv; res_taken = rt; res_target = rtgt;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic enq(input logic [15:0] pc, input logic hit, input logic [15:0] tgt);
    step(1'b1, pc, hit, tgt, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic res(input logic rt, input logic [15:0] rtgt);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, rt, rtgt);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #3;
    check("rst_ready",    32'(pred_ready), 32'd1);
    check("rst_ct",       32'(check_target), 32'd0);
    check("rst_mis",      32'(mispredict), 32'd0);
    check("rst_redirect", 32'(redirect_pc), 32'h0);
    check("rst_lookup",   32'(resolved_lookup_pc), 32'h0);
    check("rst_predpc",   32'(resolved_predicted_pc), 32'h0);
    check("rst_uflow",    32'(underflow_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct taken prediction
    enq(16'h1000, 1'b1, 16'h1040);
    res(1'b1, 16'h1040);
    check("t1_ct",     32'(check_target), 32'd1);
    check("t1_lookup", 32'(resolved_lookup_pc), 32'h1000);
    check("t1_predpc", 32'(resolved_predicted_pc), 32'h1040);
    check("t1_mis",    32'(mispredict), 32'd0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("t1_ct_pulse", 32'(check_target), 32'd0);
    check("t1_hold",     32'(resolved_lookup_pc), 32'h1000);

    // BTB miss, actually taken
    enq(16'h2000, 1'b0, 16'h0);
    res(1'b1, 16'h2100);
    check("t2_mis",      32'(mispredict), 32'd1);
    check("t2_redirect", 32'(redirect_pc), 32'h2100);
    check("t2_ct",       32'(check_target), 32'd1);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("t2_mis_pulse", 32'(mispredict), 32'd0);

    // Predicted taken, not taken; fall-through wraps 0xFFFE+2 -> 0x0000
    enq(16'hFFFE, 1'b1, 16'h0800);
    res(1'b0, 16'h0);
    check("t3_mis",      32'(mispredict), 32'd1);
    check("t3_redirect", 32'(redirect_pc), 32'h0000);
    check("t3_ct",       32'(check_target), 32'd0);
    check("t3_lookup",   32'(resolved_lookup_pc), 32'hFFFE);
`ifdef BRQ_STATS_EN
    check("stat_res", 32'(stat_resolved), 32'd3);
    check("stat_mis", 32'(stat_mispredict), 32'd2);
`endif

    // Simultaneous enqueue + correct resolve keeps FIFO order
    enq(16'h5000, 1'b0, 16'h0);
    step(1'b1, 16'h5100, 1'b1, 16'h5200, 1'b1, 1'b0, 16'h0);
    check("t4_lookupA", 32'(resolved_lookup_pc), 32'h5000);
    check("t4_misA",    32'(mispredict), 32'd0);
    check("t4_redirA",  32'(redirect_pc), 32'h5002);
    res(1'b1, 16'h5200);
    check("t4_lookupB", 32'(resolved_lookup_pc), 32'h5100);
    check("t4_ctB",     32'(check_target), 32'd1);
    check("t4_misB",    32'(mispredict), 32'd0);

    // Fill to DEPTH, 5th enqueue ignored, drain in order
    for (int i = 0; i < 4; i++) enq(16'h3000 + 16'(2 * i), 1'b0, 16'h0);
    check("t5_full", 32'(pred_ready), 32'd0);
    enq(16'h3008, 1'b0, 16'h0);
    check("t5_full_hold", 32'(pred_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      res(1'b0, 16'h0);
      check("t5_drain_pc", 32'(resolved_lookup_pc), 32'h3000 + 32'(2 * i));
      check("t5_drain_mis", 32'(mispredict), 32'd0);
    end
    check("t5_ready", 32'(pred_ready), 32'd1);
    check("t5_uflow_pre", 32'(underflow_err), 32'd0);

    // Resolve on empty queue (proves 5th entry was dropped)
    res(1'b1, 16'h9999);
    check("t6_uflow",  32'(underflow_err), 32'd1);
    check("t6_ct",     32'(check_target), 32'd0);
    check("t6_mis",    32'(mispredict), 32'd0);
    check("t6_lookup", 32'(resolved_lookup_pc), 32'h3006);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("t6_uflow_sticky", 32'(underflow_err), 32'd1);

    // Refill, mispredict on head flushes queue and drops same-cycle enqueue
    for (int i = 0; i < 4; i++) enq(16'h6000 + 16'(2 * i), 1'b0, 16'h0);
    check("t7_full", 32'(pred_ready), 32'd0);
    step(1'b1, 16'h7000, 1'b0, 16'h0, 1'b1, 1'b1, 16'h6100);
    check("t7_mis",      32'(mispredict), 32'd1);
    check("t7_redirect", 32'(redirect_pc), 32'h6100);
    check("t7_lookup",   32'(resolved_lookup_pc), 32'h6000);
    check("t7_ready",    32'(pred_ready), 32'd1);
    res(1'b1, 16'h7777);
    check("t7_empty_ct",     32'(check_target), 32'd0);
    check("t7_empty_lookup", 32'(resolved_lookup_pc), 32'h6000);
    check("t7_empty_mis",    32'(mispredict), 32'd0);

    // Asynchronous reset while a strobe is pending
    enq(16'h8000, 1'b0, 16'h0);
    pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b1; res_target = 16'h8100;
    @(posedge clk);
    #1;
    check("t8_ct_pre", 32'(check_target), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t8_ct",     32'(check_target), 32'd0);
    check("t8_mis",    32'(mispredict), 32'd0);
    check("t8_uflow",  32'(underflow_err), 32'd0);
    check("t8_lookup", 32'(resolved_lookup_pc), 32'h0);
    check("t8_ready",  32'(pred_ready), 32'd1);
`ifdef BRQ_STATS_EN
    check("t8_stat", 32'(stat_resolved), 32'd0);
`endif
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    res(1'b1, 16'h1234);
    check("t8_empty_after_rst", 32'(check_target), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
